port_ingress_queue: RTL

Per-port ingress buffer that sits directly downstream of the packet parser in the 4-port switch. It captures each presented packet together with the parser's classification (pkt_type, pkt_valid). Valid packets go into a FIFO and are presented to the switch fabric over a valid/ready interface. Invalid packets are dropped and counted. One instance per input port.

---
 rtl/port_ingress_queue.sv | 138 +++++++++++++
 1 files changed

// File: rtl/port_ingress_queue.sv
`default_nettype none
// ============================================================================
//  Module   : port_ingress_queue
//  Purpose  : Per-port ingress FIFO between the packet parser and the switch
//             fabric. Valid packets are queued and presented first-word-fall-
//             through over valid/ready. Invalid or ERR-typed packets are
//             dropped. Accepted and dropped packets are tallied in saturating
//             counters.
//  Revision : 1.0  initial release
// ============================================================================

package switch_pkg;
  typedef enum logic [1:0] {
    SDP = 2'd0,
    MDP = 2'd1,
    BDP = 2'd2,
    ERR = 2'd3
  } p_type;
endpackage

module port_ingress_queue
  import switch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_source,
  input  logic [3:0]               in_target,
  input  logic [DATA_W-1:0]        in_data,
  input  p_type                    in_type,
  input  logic                     in_pkt_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_source,
  output logic [3:0]               out_target,
  output logic [DATA_W-1:0]        out_data,
  output p_type                    out_type,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         accept_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [3:0]        source;
    logic [3:0]        target;
    logic [DATA_W-1:0] data;
    p_type             ptype;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [CNT_W-1:0]  accept_cnt_q, accept_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              fire;
  logic              accept;
  logic              drop;
  logic              pop;

  // Handshake decode; ready and valid come only from registered occupancy.
  always_comb begin
    in_ready  = (level_q != LW'(DEPTH));
    out_valid = (level_q != '0);
    fire      = in_valid && in_ready;
    accept    = fire && in_pkt_valid && (in_type != ERR);
    drop      = fire && !accept;
    pop       = out_valid && out_ready;
  end

  // Next-state for pointers, occupancy and saturating statistics.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    accept_cnt_d = accept_cnt_q;
    drop_cnt_d   = drop_cnt_q;

    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);

    case ({accept, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (accept && (accept_cnt_q != '1)) accept_cnt_d = accept_cnt_q + CNT_W'(1);
    if (drop && (drop_cnt_q != '1))     drop_cnt_d   = drop_cnt_q + CNT_W'(1);
  end

  // Control state register; reset wins over any same-cycle handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      accept_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      accept_cnt_q <= accept_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Storage array: written on accept only, never cleared.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem_q[wr_ptr_q] <= '{source: in_source, target: in_target,
                           data: in_data, ptype: in_type};
    end
  end

  // Head entry drives the fabric side directly (fall-through).
  always_comb begin
    out_source = mem_q[rd_ptr_q].source;
    out_target = mem_q[rd_ptr_q].target;
    out_data   = mem_q[rd_ptr_q].data;
    out_type   = mem_q[rd_ptr_q].ptype;
    level      = level_q;
    accept_cnt = accept_cnt_q;
    drop_cnt   = drop_cnt_q;
  end

endmodule
`default_nettype wire
